// File: rtl/tanh_lut_loader.sv
// ---------------------------------------------------------------------------
// tanh_lut_loader
//
// Runtime writer for the tanh lookup-table RAM. A host streams table words
// over a valid/ready handshake and the loader writes them to RAM addresses
// 0 .. 2^AW-1 in order. This lets the activation table be reprogrammed in
// system. Only the RAM write port is driven here; the read side is untouched.
//
// Parameters
//   AW  LUT address width (table depth = 2^AW words)
//   DW  LUT word width (raw Q-format tanh sample)
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous, active-low reset
//   start      in   1   pulse: begin a full table load (honoured only in IDLE)
//   s_valid    in   1   stream word valid
//   s_data     in   DW  stream word for the current address
//   s_last     in   1   host marks final word of the table
//   s_ready    out  1   loader accepts a word this cycle
//   mem_we     out  1   LUT RAM write enable (registered)
//   mem_addr   out  AW  LUT RAM write address (registered)
//   mem_wdata  out  DW  LUT RAM write data (registered)
//   busy       out  1   high from start acceptance until the done pulse
//   done       out  1   one-cycle pulse at end of load (normal or aborted)
//   err        out  1   sticky load error, cleared by the next accepted start
//
// Optional feature (macro LOADER_CHECKSUM_EN)
//   Adds exp_sum (in, DW, sampled on accepted start) and sum (out, DW,
//   running modulo-2^DW sum of accepted words). On normal completion the
//   final sum, including the last word, must equal exp_sum or err is set.
//   With the macro undefined neither port nor the adder exists.
// ---------------------------------------------------------------------------
module tanh_lut_loader #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
`ifdef LOADER_CHECKSUM_EN
  input  logic [DW-1:0] exp_sum,
  output logic [DW-1:0] sum,
`endif
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // count is one bit wider than the address so the final increment to 2^AW
  // is representable; the load always leaves LOAD on that beat anyway.
  localparam logic [AW:0] LAST_ADDR = (AW+1)'((1 << AW) - 1);
  localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);

  state_t          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            beat;

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0]   sum_q, sum_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic [DW-1:0]   sum_next;
`endif

  // The stream is accepted purely as a function of state, so s_ready never
  // depends on s_valid and back-to-back beats give one write per cycle.
  assign s_ready = (state_q == LOAD);
  assign beat    = s_valid & s_ready;
  assign done    = (state_q == DONE);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

`ifdef LOADER_CHECKSUM_EN
  assign sum      = sum_q;
  // Sum including the word being accepted now, used both for the running
  // update and for the end-of-table comparison.
  assign sum_next = sum_q + s_data;
`endif

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    exp_d       = exp_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          exp_d   = exp_sum;
`endif
        end
      end

      LOAD: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[AW-1:0];
          mem_wdata_d = s_data;
          count_d     = count_q + COUNT_ONE;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_next;
`endif
          if (count_q == LAST_ADDR) begin
            // Table full: the host should have flagged this word as last.
            state_d = DONE;
            if (!s_last) begin
              err_d = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            if (sum_next != exp_q) begin
              err_d = 1'b1;
            end
`endif
          end else if (s_last) begin
            // Early abort: word is still written, the rest of the table
            // keeps its previous contents.
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      exp_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      exp_q       <= exp_d;
`endif
    end
  end

endmodule
